vec_cmp_unit: RTL and testbench

VEC_CMP_UNIT -- requirements
Module: vec_cmp_unit

---
 rtl/vec_cmp_unit_pkg.sv | 38 +++
 rtl/vec_cmp_alu.sv | 37 +++
 rtl/vec_cmp_unit.sv | 175 +++++++++++++++++
 tb/tb_vec_cmp_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_cmp_unit_pkg.sv
// Shared vector-unit definitions: compare opcodes,
// operand-source encodings and the compare FSM states.
package vec_cmp_unit_pkg;

  typedef enum logic [2:0] {
    CMP_EQ  = 3'b000,
    CMP_NE  = 3'b001,
    CMP_LTU = 3'b010,
    CMP_LEU = 3'b011,
    CMP_LT  = 3'b100,
    CMP_LE  = 3'b101,
    CMP_GTU = 3'b110,
    CMP_GT  = 3'b111
  } cmp_op_e;

  // 0x selects vector-vector
  localparam logic [1:0] CE_SCA = 2'b10;
  localparam logic [1:0] CE_SCB = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_e;

  function automatic logic uses_vec_a(
    input logic [1:0] ce
  );
    return ce != CE_SCA;
  endfunction

  function automatic logic uses_vec_b(
    input logic [1:0] ce
  );
    return ce != CE_SCB;
  endfunction

endpackage

// File: rtl/vec_cmp_alu.sv
// Combinational element comparator: res_o = a_i <op> b_i.
// Ports: a_i, b_i (DATA_WIDTH), cmp_op_i (3b) -> res_o (1b).
module vec_cmp_alu
  import vec_cmp_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [2:0]            cmp_op_i,
  output logic                  res_o
);

  logic eq;
  logic ltu;
  logic lts;

  assign eq  = (a_i == b_i);
  assign ltu = (a_i < b_i);
  assign lts = ($signed(a_i) < $signed(b_i));

  always_comb begin
    res_o = 1'b0;
    unique case (cmp_op_e'(cmp_op_i))
      CMP_EQ:  res_o = eq;
      CMP_NE:  res_o = !eq;
      CMP_LTU: res_o = ltu;
      CMP_LEU: res_o = ltu | eq;
      CMP_LT:  res_o = lts;
      CMP_LE:  res_o = lts | eq;
      CMP_GTU: res_o = !(ltu | eq);
      CMP_GT:  res_o = !(lts | eq);
      default: res_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/vec_cmp_unit.sv
// Vector compare unit: streams element pairs, emits one result
// bit per element and accumulates them into res_mask.
// Ports: clk_i, rst (sync, active high), start, cmp_op, cont_esc,
//   op_esc, mask, VLR, arg1/arg2 ({valid,data}), arg_ready,
//   out_valid/out_bit/out_idx, res_mask, busy, done.
// Build option: define VEC_CMP_MASK_EN to zero the result of
//   masked-off elements; otherwise the mask port is ignored.
module vec_cmp_unit
  import vec_cmp_unit_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int MVL        = 16,
  localparam int CW         = (MVL > 1) ? $clog2(MVL) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            cmp_op,
  input  logic [1:0]            cont_esc,
  input  logic [DATA_WIDTH-1:0] op_esc,
  input  logic [MVL-1:0]        mask,
  input  logic [CW:0]           VLR,
  input  logic [DATA_WIDTH:0]   arg1,
  input  logic [DATA_WIDTH:0]   arg2,
  output logic                  arg_ready,
  output logic                  out_valid,
  output logic                  out_bit,
  output logic [CW-1:0]         out_idx,
  output logic [MVL-1:0]        res_mask,
  output logic                  busy,
  output logic                  done
);

  state_e                state_q, state_d;
  logic [CW:0]           cnt_q, cnt_d;
  logic [MVL-1:0]        res_q, res_d;
  logic                  ov_q, ov_d;
  logic                  ob_q, ob_d;
  logic [CW-1:0]         oidx_q, oidx_d;
  logic [2:0]            op_q, op_d;
  logic [1:0]            ce_q, ce_d;
  logic [DATA_WIDTH-1:0] esc_q, esc_d;
  logic [CW:0]           vlr_q, vlr_d;

  logic                  accept;
  logic                  vld_ok;
  logic [DATA_WIDTH-1:0] opa;
  logic [DATA_WIDTH-1:0] opb;
  logic                  alu_res;
  logic                  elem_bit;
  logic [CW-1:0]         idx;

  assign accept = (state_q == S_IDLE) && start;
  assign idx    = cnt_q[CW-1:0];

  assign opa = uses_vec_a(ce_q) ? arg1[DATA_WIDTH-1:0] : esc_q;
  assign opb = uses_vec_b(ce_q) ? arg2[DATA_WIDTH-1:0] : esc_q;

  // Scalar-replaced operands never gate consumption
  assign vld_ok =
    (!uses_vec_a(ce_q) || arg1[DATA_WIDTH]) &&
    (!uses_vec_b(ce_q) || arg2[DATA_WIDTH]);

  // Counter guard stops consumption while the last result drains
  assign arg_ready =
    (state_q == S_RUN) && (cnt_q < vlr_q) && vld_ok;

  vec_cmp_alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .a_i      (opa),
    .b_i      (opb),
    .cmp_op_i (op_q),
    .res_o    (alu_res)
  );

`ifdef VEC_CMP_MASK_EN
  logic [MVL-1:0] mask_q;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      mask_q <= '0;
    end else if (accept) begin
      mask_q <= mask;
    end
  end

  assign elem_bit = alu_res & mask_q[idx];
`else
  logic unused_mask;

  assign unused_mask = ^mask;
  assign elem_bit    = alu_res;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ov_d    = 1'b0;
    ob_d    = ob_q;
    oidx_d  = oidx_q;
    op_d    = op_q;
    ce_d    = ce_q;
    esc_d   = esc_q;
    vlr_d   = vlr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = cmp_op;
          ce_d    = cont_esc;
          esc_d   = op_esc;
          vlr_d   = VLR;
          cnt_d   = '0;
          res_d   = '0;
          state_d = (VLR == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (arg_ready) begin
          cnt_d      = cnt_q + (CW+1)'(1);
          ov_d       = 1'b1;
          ob_d       = elem_bit;
          oidx_d     = idx;
          res_d[idx] = elem_bit;
        end
        // Leave only once the final result is on the outputs,
        // so done trails the last out_valid by one cycle
        if (ov_q && (cnt_q == vlr_q)) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      ov_q    <= 1'b0;
      ob_q    <= 1'b0;
      oidx_q  <= '0;
      op_q    <= '0;
      ce_q    <= '0;
      esc_q   <= '0;
      vlr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ov_q    <= ov_d;
      ob_q    <= ob_d;
      oidx_q  <= oidx_d;
      op_q    <= op_d;
      ce_q    <= ce_d;
      esc_q   <= esc_d;
      vlr_q   <= vlr_d;
    end
  end

  assign out_valid = ov_q;
  assign out_bit   = ob_q;
  assign out_idx   = oidx_q;
  assign res_mask  = res_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_FIN);
  assign done      = (state_q == S_FIN);

endmodule

// File: tb/tb_vec_cmp_unit.sv
// Scoreboard bench for vec_cmp_unit: directed vectors push
// expected element results; a monitor pops them on out_valid.
module tb_vec_cmp_unit;

  logic        clk_i;
  logic        rst;
  logic        start;
  logic [2:0]  cmp_op;
  logic [1:0]  cont_esc;
  logic [31:0] op_esc;
  logic [15:0] mask;
  logic [4:0]  VLR;
  logic [32:0] arg1;
  logic [32:0] arg2;
  logic        arg_ready;
  logic        out_valid;
  logic        out_bit;
  logic [3:0]  out_idx;
  logic [15:0] res_mask;
  logic        busy;
  logic        done;

  typedef struct {
    logic [3:0] idx;
    logic       b;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_ov = -100;

  vec_cmp_unit u_dut (
    .clk_i     (clk_i),
    .rst       (rst),
    .start     (start),
    .cmp_op    (cmp_op),
    .cont_esc  (cont_esc),
    .op_esc    (op_esc),
    .mask      (mask),
    .VLR       (VLR),
    .arg1      (arg1),
    .arg2      (arg2),
    .arg_ready (arg_ready),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .out_idx   (out_idx),
    .res_mask  (res_mask),
    .busy      (busy),
    .done      (done)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (out_valid === 1'b1) begin
      exp_t e;
      last_ov = cyc;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid act=idx%0d exp=none",
                 out_idx);
      end else begin
        e = sb.pop_front();
        chk("ov_idx", 64'(out_idx), 64'(e.idx));
        chk("ov_bit", 64'(out_bit), 64'(e.b));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_vec(
    input string       nm,
    input logic [2:0]  op,
    input logic [1:0]  ce,
    input logic [31:0] esc,
    input logic [15:0] msk,
    input int          n,
    input logic [31:0] a1 [8],
    input logic [31:0] a2 [8],
    input logic        v1,
    input logic        v2,
    input logic [7:0]  ex,
    input int          stall_at
  );
    int w;
    cmp_op   = op;
    cont_esc = ce;
    op_esc   = esc;
    mask     = msk;
    VLR      = 5'(n);
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk({nm, "_busy"}, 64'(busy), 64'd1);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        arg1 = {1'b0, a1[i]};
        arg2 = {v2, a2[i]};
        for (int k = 0; k < 3; k++) begin
          #1;
          chk({nm, "_stall_rdy"}, 64'(arg_ready), 64'd0);
          if (k > 0) begin
            chk({nm, "_stall_ov"}, 64'(out_valid), 64'd0);
            chk({nm, "_stall_idx"}, 64'(out_idx), 64'(i - 1));
          end
          tick();
        end
      end
      arg1 = {v1, a1[i]};
      arg2 = {v2, a2[i]};
      sb.push_back('{idx: 4'(i), b: ex[i]});
      #1;
      chk({nm, "_rdy"}, 64'(arg_ready), 64'd1);
      tick();
    end
    arg1 = '0;
    arg2 = '0;
    w = 0;
    while (done !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    chk({nm, "_done"}, 64'(done), 64'd1);
    chk({nm, "_done_lat"}, 64'(cyc - last_ov), 64'd1);
    chk({nm, "_res"}, 64'(res_mask), 64'(ex));
    chk({nm, "_sb_empty"}, 64'(sb.size()), 64'd0);
    tick();
    chk({nm, "_idle"}, 64'(busy), 64'd0);
  endtask

  logic [31:0] A [8];
  logic [31:0] B [8];
  logic [7:0]  tbl_neg;
  logic [7:0]  tbl_eq;
  logic [7:0]  mexp;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    cmp_op   = '0;
    cont_esc = '0;
    op_esc   = '0;
    mask     = '0;
    VLR      = '0;
    arg1     = '0;
    arg2     = '0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_res", 64'(res_mask), 64'd0);
    chk("rst_idx", 64'(out_idx), 64'd0);
    rst = 1'b0;
    tick();

    A = '{5, 1, 9, 3, 0, 0, 0, 0};
    B = '{2, 1, 4, 7, 0, 0, 0, 0};
    run_vec("gtu", 3'b110, 2'b00, 0, 16'hffff, 4, A, B,
            1'b1, 1'b1, 8'b0101, -1);

    A = '{32'hffffffff, 2, 0, 0, 0, 0, 0, 0};
    B = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_vec("lt_scb", 3'b100, 2'b11, 0, 16'hffff, 2, A, B,
            1'b1, 1'b0, 8'b01, -1);

    A = '{0, 0, 0, 0, 0, 0, 0, 0};
    B = '{9, 5, 2, 0, 0, 0, 0, 0};
    run_vec("ltu_sca", 3'b010, 2'b10, 5, 16'hffff, 3, A, B,
            1'b0, 1'b1, 8'b001, -1);

    A = '{7, 8, 9, 10, 0, 0, 0, 0};
    B = '{7, 0, 9, 10, 0, 0, 0, 0};
    run_vec("stall", 3'b000, 2'b00, 0, 16'hffff, 4, A, B,
            1'b1, 1'b1, 8'b1101, 2);

    // A=-1, B=1; bit k = expected result of cmp_op k
    tbl_neg = 8'b0111_0010;
    // A=B=3
    tbl_eq  = 8'b0010_1001;
    for (int op = 0; op < 8; op++) begin
      A = '{32'hffffffff, 0, 0, 0, 0, 0, 0, 0};
      B = '{1, 0, 0, 0, 0, 0, 0, 0};
      run_vec($sformatf("opn%0d", op), 3'(op), 2'b00, 0,
              16'hffff, 1, A, B, 1'b1, 1'b1,
              {7'b0, tbl_neg[op]}, -1);
      A = '{3, 0, 0, 0, 0, 0, 0, 0};
      B = '{3, 0, 0, 0, 0, 0, 0, 0};
      run_vec($sformatf("ope%0d", op), 3'(op), 2'b00, 0,
              16'hffff, 1, A, B, 1'b1, 1'b1,
              {7'b0, tbl_eq[op]}, -1);
    end

    VLR   = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("vlr0_busy", 64'(busy), 64'd1);
    chk("vlr0_done", 64'(done), 64'd1);
    chk("vlr0_ov", 64'(out_valid), 64'd0);
    chk("vlr0_res", 64'(res_mask), 64'd0);
    tick();
    chk("vlr0_busy_end", 64'(busy), 64'd0);
    chk("vlr0_done_end", 64'(done), 64'd0);

`ifdef VEC_CMP_MASK_EN
    mexp = 8'b10;
`else
    mexp = 8'b11;
`endif
    A = '{3, 4, 0, 0, 0, 0, 0, 0};
    B = '{3, 4, 0, 0, 0, 0, 0, 0};
    run_vec("mask", 3'b000, 2'b00, 0, 16'h0002, 2, A, B,
            1'b1, 1'b1, mexp, -1);

    cmp_op   = 3'b001;
    cont_esc = 2'b00;
    VLR      = 5'd8;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      arg1 = {1'b1, 32'(i)};
      arg2 = {1'b1, 32'd0};
      sb.push_back('{idx: 4'(i), b: (i != 0)});
      tick();
    end
    arg1 = {1'b1, 32'd2};
    rst  = 1'b1;
    tick();
    arg1 = '0;
    arg2 = '0;
    chk("mrst_ov", 64'(out_valid), 64'd0);
    chk("mrst_bit", 64'(out_bit), 64'd0);
    chk("mrst_idx", 64'(out_idx), 64'd0);
    chk("mrst_res", 64'(res_mask), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_sb", 64'(sb.size()), 64'd0);
    rst = 1'b0;
    A = '{1, 0, 0, 0, 0, 0, 0, 0};
    B = '{2, 0, 0, 0, 0, 0, 0, 0};
    run_vec("after_rst", 3'b001, 2'b00, 0, 16'hffff, 1, A, B,
            1'b1, 1'b1, 8'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
